// File: rtl/ic_mem_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter: FSM state
// encoding, requester indices and bus widths.
package ic_mem_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int STRB_W = 4;

  localparam logic P_IMEM = 1'b0;
  localparam logic P_DMEM = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_BUSY   = 2'd2
  } arb_state_t;

  function automatic logic other_port(input logic p);
    return ~p;
  endfunction

endpackage

// File: rtl/ic_mem_arbiter_if.sv
// Interconnect bus: req/gnt request phase, recv/ack response phase.
// The master drives the request and ack; the slave drives gnt and the response.
interface ic_mem_arbiter_if;
  import ic_mem_arbiter_pkg::*;

  logic              req;
  logic              wen;
  logic [STRB_W-1:0] strb;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] addr;
  logic              gnt;
  logic              recv;
  logic              ack;
  logic              error;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wen, strb, wdata, addr, ack,
    input  gnt, recv, error, rdata
  );

  modport slave (
    input  req, wen, strb, wdata, addr, ack,
    output gnt, recv, error, rdata
  );

endinterface

// File: rtl/ic_mem_arbiter_sel.sv
// Combinational winner select for the arbiter. While locked the selection is
// pinned to the current owner so a stalled request cannot be swapped out.
module ic_arb_sel
  import ic_mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic p0_req,
  input  logic p1_req,
  input  logic prio,
  input  logic lock,
  input  logic owner,
  output logic winner,
  output logic win_req
);

  always_comb begin
    winner = P_IMEM;
    if (lock) begin
      winner = owner;
    end else if (p0_req && p1_req) begin
      winner = (FIXED_PRIO != 0) ? P_DMEM : prio;
    end else if (p1_req) begin
      winner = P_DMEM;
    end
    win_req = winner ? p1_req : p0_req;
  end

endmodule

// File: rtl/ic_mem_arbiter.sv
// Two-requester arbiter in front of a single-port memory target, one
// transaction outstanding. Optional counters enabled with IC_ARB_PERF_EN.
module ic_mem_arbiter
  import ic_mem_arbiter_pkg::*;
#(
  parameter int FIXED_PRIO = 0,
  parameter int RESET_PRIO = 1
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  ic_mem_arbiter_if.slave   p0,
  ic_mem_arbiter_if.slave   p1,
  ic_mem_arbiter_if.master  tgt
`ifdef IC_ARB_PERF_EN
  ,
  output logic [31:0]       perf_p0_grants,
  output logic [31:0]       perf_p1_grants,
  output logic [31:0]       perf_stall_cycles
`endif
);

  localparam logic RST_PRIO = (RESET_PRIO != 0);

  arb_state_t state;
  logic       owner;
  logic       prio;
  logic       winner;
  logic       win_req;
  logic       owner_ack;

  ic_arb_sel #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_sel (
    .p0_req  (p0.req),
    .p1_req  (p1.req),
    .prio    (prio),
    .lock    (state == ST_LOCKED),
    .owner   (owner),
    .winner  (winner),
    .win_req (win_req)
  );

  assign owner_ack = owner ? p1.ack : p0.ack;

  // Request and response routing is purely combinational so neither path adds latency.
  always_comb begin
    tgt.req   = 1'b0;
    tgt.wen   = 1'b0;
    tgt.strb  = '0;
    tgt.wdata = '0;
    tgt.addr  = '0;
    tgt.ack   = 1'b0;
    p0.gnt    = 1'b0;
    p1.gnt    = 1'b0;
    p0.recv   = 1'b0;
    p1.recv   = 1'b0;
    p0.error  = 1'b0;
    p1.error  = 1'b0;
    p0.rdata  = '0;
    p1.rdata  = '0;
    case (state)
      ST_IDLE, ST_LOCKED: begin
        if (win_req) begin
          tgt.req = 1'b1;
          if (winner) begin
            tgt.wen   = p1.wen;
            tgt.strb  = p1.strb;
            tgt.wdata = p1.wdata;
            tgt.addr  = p1.addr;
            p1.gnt    = tgt.gnt;
          end else begin
            tgt.wen   = p0.wen;
            tgt.strb  = p0.strb;
            tgt.wdata = p0.wdata;
            tgt.addr  = p0.addr;
            p0.gnt    = tgt.gnt;
          end
        end
      end
      ST_BUSY: begin
        tgt.ack = owner_ack;
        if (owner) begin
          p1.recv  = tgt.recv;
          p1.error = tgt.error;
          p1.rdata = tgt.rdata;
        end else begin
          p0.recv  = tgt.recv;
          p0.error = tgt.error;
          p0.rdata = tgt.rdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      state <= ST_IDLE;
      owner <= P_IMEM;
      prio  <= RST_PRIO;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_req) begin
            owner <= winner;
            if (tgt.gnt) begin
              state <= ST_BUSY;
              prio  <= other_port(winner);
            end else begin
              state <= ST_LOCKED;
            end
          end
        end
        ST_LOCKED: begin
          if (win_req && tgt.gnt) begin
            state <= ST_BUSY;
            prio  <= other_port(owner);
          end
        end
        ST_BUSY: begin
          if (tgt.recv && owner_ack) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef IC_ARB_PERF_EN
  // Counters wrap naturally at 2^32.
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      perf_p0_grants    <= '0;
      perf_p1_grants    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (p0.gnt) perf_p0_grants <= perf_p0_grants + 32'd1;
      if (p1.gnt) perf_p1_grants <= perf_p1_grants + 32'd1;
      if ((p0.req && !p0.gnt) || (p1.req && !p1.gnt))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ic_mem_arbiter.sv
// Directed bench for ic_mem_arbiter: a round-robin and a fixed-priority
// instance share the same stimulus and are checked against a bench model.
module tb_ic_mem_arbiter;

  logic g_clk = 1'b0;
  logic g_resetn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 g_clk = ~g_clk;

  ic_mem_arbiter_if p0a ();
  ic_mem_arbiter_if p1a ();
  ic_mem_arbiter_if ta ();
  ic_mem_arbiter_if p0b ();
  ic_mem_arbiter_if p1b ();
  ic_mem_arbiter_if tgt_b ();

  assign p0b.req     = p0a.req;
  assign p0b.wen     = p0a.wen;
  assign p0b.strb    = p0a.strb;
  assign p0b.wdata   = p0a.wdata;
  assign p0b.addr    = p0a.addr;
  assign p0b.ack     = p0a.ack;
  assign p1b.req     = p1a.req;
  assign p1b.wen     = p1a.wen;
  assign p1b.strb    = p1a.strb;
  assign p1b.wdata   = p1a.wdata;
  assign p1b.addr    = p1a.addr;
  assign p1b.ack     = p1a.ack;
  assign tgt_b.gnt   = ta.gnt;
  assign tgt_b.recv  = ta.recv;
  assign tgt_b.error = ta.error;
  assign tgt_b.rdata = ta.rdata;

`ifdef IC_ARB_PERF_EN
  logic [31:0] pa_g0, pa_g1, pa_st, pb_g0, pb_g1, pb_st;
`endif

  ic_mem_arbiter #(.FIXED_PRIO(0), .RESET_PRIO(1)) dut_rr (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .p0       (p0a),
    .p1       (p1a),
    .tgt      (ta)
`ifdef IC_ARB_PERF_EN
    , .perf_p0_grants (pa_g0), .perf_p1_grants (pa_g1), .perf_stall_cycles (pa_st)
`endif
  );

  ic_mem_arbiter #(.FIXED_PRIO(1), .RESET_PRIO(1)) dut_fx (
    .g_clk    (g_clk),
    .g_resetn (g_resetn),
    .p0       (p0b),
    .p1       (p1b),
    .tgt      (tgt_b)
`ifdef IC_ARB_PERF_EN
    , .perf_p0_grants (pb_g0), .perf_p1_grants (pb_g1), .perf_stall_cycles (pb_st)
`endif
  );

  // Model: 0 = free, 1 = waiting on target grant, 2 = awaiting response
  int   m_phase [2];
  logic m_owner [2];
  logic m_turn  [2];
  bit   m_valid [2];
`ifdef IC_ARB_PERF_EN
  logic [31:0] m_g0 [2], m_g1 [2], m_st [2];
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit fixed,
                            input logic a_gnt0, a_gnt1, a_recv0, a_recv1, a_err0, a_err1,
                            input logic [31:0] a_rd0, a_rd1,
                            input logic a_treq, a_twen, input logic [3:0] a_tstrb,
                            input logic [31:0] a_twdata, a_taddr, input logic a_tack);
    logic cand, active;
    logic e_gnt0, e_gnt1, e_recv0, e_recv1, e_err0, e_err1, e_treq, e_twen, e_tack;
    logic [3:0] e_tstrb;
    logic [31:0] e_rd0, e_rd1, e_twdata, e_taddr;
    logic [140:0] act_v, exp_v;
    {e_gnt0, e_gnt1, e_recv0, e_recv1, e_err0, e_err1, e_treq, e_twen, e_tack} = '0;
    e_tstrb = '0; e_rd0 = '0; e_rd1 = '0; e_twdata = '0; e_taddr = '0;
    cand = 1'b0; active = 1'b0;
    if (m_phase[k] != 2) begin
      if (m_phase[k] == 1) cand = m_owner[k];
      else if (p0a.req && p1a.req) cand = fixed ? 1'b1 : m_turn[k];
      else cand = p1a.req;
      active = cand ? p1a.req : p0a.req;
      if (active) begin
        e_treq   = 1'b1;
        e_twen   = cand ? p1a.wen   : p0a.wen;
        e_tstrb  = cand ? p1a.strb  : p0a.strb;
        e_twdata = cand ? p1a.wdata : p0a.wdata;
        e_taddr  = cand ? p1a.addr  : p0a.addr;
        if (cand) e_gnt1 = ta.gnt; else e_gnt0 = ta.gnt;
      end
    end else if (m_owner[k]) begin
      e_recv1 = ta.recv; e_err1 = ta.error; e_rd1 = ta.rdata; e_tack = p1a.ack;
    end else begin
      e_recv0 = ta.recv; e_err0 = ta.error; e_rd0 = ta.rdata; e_tack = p0a.ack;
    end
    if (m_valid[k]) begin
      act_v = {a_gnt0, a_gnt1, a_recv0, a_recv1, a_err0, a_err1, a_rd0, a_rd1,
               a_treq, a_twen, a_tstrb, a_twdata, a_taddr, a_tack};
      exp_v = {e_gnt0, e_gnt1, e_recv0, e_recv1, e_err0, e_err1, e_rd0, e_rd1,
               e_treq, e_twen, e_tstrb, e_twdata, e_taddr, e_tack};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model_dut%0d t=%0t actual=%h required=%h", k, $time, act_v, exp_v);
      end
      checks++;
      if ((a_gnt0 & a_gnt1) !== 1'b0 || (a_recv0 & a_recv1) !== 1'b0) begin
        failures++;
        $display("FAIL onehot_dut%0d t=%0t actual=%b%b%b%b required=no pair high",
                 k, $time, a_gnt0, a_gnt1, a_recv0, a_recv1);
      end
    end
    if (!g_resetn) begin
      m_phase[k] = 0; m_owner[k] = 1'b0; m_turn[k] = 1'b1; m_valid[k] = 1'b1;
`ifdef IC_ARB_PERF_EN
      m_g0[k] = 0; m_g1[k] = 0; m_st[k] = 0;
`endif
    end else begin
`ifdef IC_ARB_PERF_EN
      if (e_gnt0) m_g0[k] = m_g0[k] + 1;
      if (e_gnt1) m_g1[k] = m_g1[k] + 1;
      if ((p0a.req && !e_gnt0) || (p1a.req && !e_gnt1)) m_st[k] = m_st[k] + 1;
`endif
      if (m_phase[k] == 0) begin
        if (active) begin
          m_owner[k] = cand;
          if (ta.gnt) begin m_phase[k] = 2; m_turn[k] = ~cand; end
          else m_phase[k] = 1;
        end
      end else if (m_phase[k] == 1) begin
        if (active && ta.gnt) begin m_phase[k] = 2; m_turn[k] = ~m_owner[k]; end
      end else if (ta.recv && (m_owner[k] ? p1a.ack : p0a.ack)) begin
        m_phase[k] = 0;
      end
    end
  endtask

  always @(negedge g_clk) begin
`ifdef IC_ARB_PERF_EN
    if (m_valid[0]) begin
      chk("perf_rr", {pa_g0 ^ m_g0[0]} | {pa_g1 ^ m_g1[0]} | {pa_st ^ m_st[0]}, 32'd0);
      chk("perf_fx", {pb_g0 ^ m_g0[1]} | {pb_g1 ^ m_g1[1]} | {pb_st ^ m_st[1]}, 32'd0);
    end
`endif
    model_step(0, 1'b0, p0a.gnt, p1a.gnt, p0a.recv, p1a.recv, p0a.error, p1a.error,
               p0a.rdata, p1a.rdata, ta.req, ta.wen, ta.strb, ta.wdata, ta.addr, ta.ack);
    model_step(1, 1'b1, p0b.gnt, p1b.gnt, p0b.recv, p1b.recv, p0b.error, p1b.error,
               p0b.rdata, p1b.rdata, tgt_b.req, tgt_b.wen, tgt_b.strb, tgt_b.wdata,
               tgt_b.addr, tgt_b.ack);
  end

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic clr();
    p0a.req = 0; p0a.wen = 0; p0a.strb = 0; p0a.wdata = 0; p0a.addr = 0; p0a.ack = 0;
    p1a.req = 0; p1a.wen = 0; p1a.strb = 0; p1a.wdata = 0; p1a.addr = 0; p1a.ack = 0;
    ta.gnt = 0; ta.recv = 0; ta.error = 0; ta.rdata = 0;
  endtask

  task automatic do_reset();
    g_resetn = 1'b0;
    clr();
    cyc();
    cyc();
    g_resetn = 1'b1;
  endtask

  logic q_rr [$];
  logic q_fx [$];
  logic exp_rr [4] = '{1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    m_valid[0] = 0; m_valid[1] = 0;
    clr();
    do_reset();
    @(negedge g_clk);
    chk("reset_tgt_req", ta.req, 0);
    chk("reset_p0_gnt", p0a.gnt, 0);

    // Single read from the instruction side
    cyc(); p0a.req = 1; p0a.addr = 32'h2000_0010; ta.gnt = 1;
    @(negedge g_clk);
    chk("single_p0_gnt", p0a.gnt, 1);
    chk("single_tgt_addr", ta.addr, 32'h2000_0010);
    cyc(); clr(); ta.recv = 1; ta.rdata = 32'hDEAD_BEEF; p0a.ack = 1;
    @(negedge g_clk);
    chk("single_p0_rdata", p0a.rdata, 32'hDEAD_BEEF);
    chk("single_p0_recv", p0a.recv, 1);
    chk("single_p1_recv", p1a.recv, 0);
    chk("single_tgt_ack", ta.ack, 1);
    cyc(); clr();

    // Continuous contention from reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cyc(); clr();
      p0a.req = 1; p0a.addr = 32'h0000_0100; p0a.wdata = 32'h1111_0000;
      p1a.req = 1; p1a.addr = 32'h0000_0200; p1a.wen = 1; p1a.strb = 4'hF;
      p1a.wdata = 32'h2222_0000;
      if (i % 2 == 0) ta.gnt = 1;
      else begin ta.recv = 1; ta.rdata = i; p0a.ack = 1; p1a.ack = 1; end
      @(negedge g_clk);
      if (p0a.gnt) q_rr.push_back(1'b0);
      if (p1a.gnt) q_rr.push_back(1'b1);
      if (p0b.gnt) q_fx.push_back(1'b0);
      if (p1b.gnt) q_fx.push_back(1'b1);
    end
    cyc(); clr();
    chk("rr_grant_count", q_rr.size(), 4);
    chk("fx_grant_count", q_fx.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < q_rr.size()) chk($sformatf("rr_order%0d", i), q_rr[i], exp_rr[i]);
      if (i < q_fx.size()) chk($sformatf("fx_order%0d", i), q_fx[i], 1);
    end

    // Target stalls the grant while the other port starts requesting
    do_reset();
    cyc(); p0a.req = 1; p0a.addr = 32'h3000_0000;
    @(negedge g_clk);
    chk("lock_c0_addr", ta.addr, 32'h3000_0000);
    for (int c = 1; c < 3; c++) begin
      cyc(); p1a.req = 1; p1a.addr = 32'h4000_0000;
      @(negedge g_clk);
      chk("lock_rr_addr", ta.addr, 32'h3000_0000);
      chk("lock_fx_addr", tgt_b.addr, 32'h3000_0000);
      chk("lock_p1_gnt", p1b.gnt, 0);
    end
    cyc(); ta.gnt = 1;
    @(negedge g_clk);
    chk("lock_rr_p0_gnt", p0a.gnt, 1);
    chk("lock_fx_p0_gnt", p0b.gnt, 1);
    chk("lock_fx_p1_gnt", p1b.gnt, 0);
    cyc(); p0a.req = 0; ta.gnt = 1; ta.recv = 1; p0a.ack = 0;
    @(negedge g_clk);
    chk("busy_p1_gnt", p1a.gnt, 0);
    chk("busy_fx_p1_gnt", p1b.gnt, 0);
    cyc(); ta.gnt = 0; p0a.ack = 1;
    @(negedge g_clk);
    chk("lock_p0_recv", p0a.recv, 1);
    cyc(); ta.recv = 0; p0a.ack = 0; ta.gnt = 1;
    @(negedge g_clk);
    chk("after_lock_p1_gnt", p1a.gnt, 1);
    chk("after_lock_fx_p1_gnt", p1b.gnt, 1);
    cyc(); p1a.req = 0; ta.gnt = 0; ta.recv = 1; p1a.ack = 1;
    @(negedge g_clk);
    cyc(); clr();

    // Response backpressure with error on the data side
    p1a.req = 1; p1a.wen = 1; p1a.strb = 4'hF; p1a.wdata = 32'h0000_55AA;
    p1a.addr = 32'h5000_0004; ta.gnt = 1;
    @(negedge g_clk);
    chk("bp_p1_gnt", p1a.gnt, 1);
    chk("bp_tgt_wen", ta.wen, 1);
    chk("bp_tgt_wdata", ta.wdata, 32'h0000_55AA);
    for (int c = 0; c < 3; c++) begin
      cyc(); clr(); ta.recv = 1; ta.error = 1; ta.rdata = 32'h1234; p1a.ack = (c == 2);
      @(negedge g_clk);
      chk("bp_p1_recv", p1a.recv, 1);
      chk("bp_p1_error", p1a.error, 1);
      chk("bp_tgt_ack", ta.ack, (c == 2) ? 1 : 0);
    end
    cyc(); clr(); p0a.req = 1; p0a.addr = 32'h6000_0000; ta.gnt = 1; ta.recv = 1;
    p0a.ack = 1;
    @(negedge g_clk);
    chk("idle_p0_gnt", p0a.gnt, 1);
    chk("idle_stray_recv", p0a.recv, 0);
    chk("idle_stray_ack", ta.ack, 0);
    cyc(); clr(); ta.recv = 1; p0a.ack = 1;
    cyc(); clr();

    // Reset while a response is pending
    p0a.req = 1; ta.gnt = 1;
    cyc(); clr(); ta.recv = 1; ta.rdata = 32'h0000_CAFE; g_resetn = 0;
    @(negedge g_clk);
    chk("rst_busy_p0_recv", p0a.recv, 1);
    cyc(); g_resetn = 1; p0a.ack = 1;
    @(negedge g_clk);
    chk("rst_p0_recv", p0a.recv, 0);
    chk("rst_p0_rdata", p0a.rdata, 0);
    chk("rst_tgt_ack", ta.ack, 0);
    chk("rst_tgt_req", ta.req, 0);
`ifdef IC_ARB_PERF_EN
    chk("rst_perf_g0", pa_g0, 0);
    chk("rst_perf_g1", pa_g1, 0);
    chk("rst_perf_st", pa_st, 0);
`endif
    cyc(); clr();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ic_mem_arbiter.md
Name: ic_mem_arbiter

Overview:
- Shares one single-port memory target (e.g. the RAM) between two requesters: port 0 = CPU instruction side, port 1 = CPU data side.
- Sits behind the interconnect address decode, in front of the RAM.
- Uses the interconnect protocol on all ports: req/gnt request phase, recv/ack response phase.
- Keeps at most one transaction outstanding and routes each response back to the requester that was granted.

Parameters:
- FIXED_PRIO, 0: 0 = round-robin; 1 = port 1 always wins on contention.
- RESET_PRIO, 1: port given priority after reset when round-robin.

Ports:
- g_clk  in  1  clock
- g_resetn  in  1  synchronous active-low reset
- pN_req  in  1  request, N = 0,1 (held until pN_gnt)
- pN_wen  in  1  write enable
- pN_strb  in  4  write strobe
- pN_wdata  in  32  write data
- pN_addr  in  32  address
- pN_gnt  out  1  request accepted
- pN_recv  out  1  response valid
- pN_ack  in  1  response accepted
- pN_error  out  1  response error
- pN_rdata  out  32  read data
- tgt_req  out  1  request to target
- tgt_wen  out  1  write enable
- tgt_strb  out  4  write strobe
- tgt_wdata  out  32  write data
- tgt_addr  out  32  address
- tgt_gnt  in  1  target accepted request
- tgt_recv  in  1  target response valid
- tgt_ack  out  1  response accepted
- tgt_error  in  1  target error
- tgt_rdata  in  32  target read data

Behaviour:
- Reset: g_resetn synchronous, active-low, on g_clk.
  - State IDLE, lock = 0, owner = 0, prio = RESET_PRIO.
  - All outputs 0, since they are combinational from state.
- States: IDLE, LOCKED, BUSY.
- IDLE:
  - winner = sole requester; on contention, the prio port (round-robin) or port 1 (FIXED_PRIO = 1).
  - tgt_req = winner req. tgt_wen/strb/wdata/addr are muxed from the winner; they are 0 when there is no request.
  - winner pN_gnt = tgt_gnt, combinational; loser pN_gnt = 0.
  - tgt_req & tgt_gnt -> owner <= winner, go BUSY.
  - tgt_req & !tgt_gnt -> owner <= winner, go LOCKED.
- LOCKED (target stalling grant): selection is frozen to owner, even if the other port raises req or has priority.
  - tgt_gnt -> go BUSY.
- BUSY:
  - tgt_req = 0; both pN_gnt = 0.
  - owner pN_recv/error/rdata = tgt_recv/error/rdata; non-owner outputs = 0.
  - tgt_ack = owner pN_ack.
  - tgt_recv & owner ack -> go IDLE.
  - Response outputs are pass-through, so they stay stable while recv & !ack exactly as long as the target holds them.
- Latency: zero added cycles on request and response paths.
- Back-to-back: minimum one IDLE cycle between transactions, so the peak is one transaction per 2 cycles when the target grants and responds same-cycle.
- Round-robin: on each accepted grant, prio <= the non-granted port. FIXED_PRIO = 1 ignores prio.
- Simultaneous events:
  - Both requests in the same cycle -> exactly one gnt.
  - A request arriving in BUSY waits; no gnt until IDLE.
- Target raising tgt_recv outside BUSY is ignored: no pN_recv, tgt_ack = 0.
- Reset mid-transaction returns to IDLE and drops ownership; a target response in flight is discarded.
- Invariants:
  - p0_gnt & p1_gnt never both high.
  - p0_recv & p1_recv never both high.

Optional Feature:
- Macro IC_ARB_PERF_EN.
- Defined: adds outputs perf_p0_grants (32), perf_p1_grants (32) and perf_stall_cycles (32).
  - Grant counters increment on each accepted grant for that port.
  - perf_stall_cycles increments each cycle a pN_req is high with its pN_gnt low.
  - All counters wrap, and reset to 0.
- Not defined: the perf ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared header ic_arb_defs.vh: state encodings (IDLE = 2'd0, LOCKED = 2'd1, BUSY = 2'd2) and port index constants (P_IMEM = 0, P_DMEM = 1).
- Sub-module ic_arb_sel: combinational winner select from p0_req, p1_req, prio, FIXED_PRIO and lock/owner.

Test Plan:
- Single request: p0 read addr 0x2000_0010, tgt_gnt = 1 same cycle, tgt_recv + rdata 0xDEADBEEF next cycle -> p0_gnt same cycle as req; p0_rdata = 0xDEADBEEF; p1_recv = 0.
- Contention, round-robin: both req every cycle for 4 transactions from reset (RESET_PRIO = 1) -> grant order p1, p0, p1, p0.
- FIXED_PRIO = 1 with both req continuously for 3 transactions -> p1 granted 3 times, p0 never.
- Grant stall lock: p0 req, tgt_gnt low 3 cycles, p1 raises req in cycle 1 -> tgt_addr stays p0_addr; p0 granted in cycle 3; p1 granted only after p0's response acked.
- Response backpressure: tgt_recv = 1, tgt_error = 1, p1 owner, p1_ack low 2 cycles -> p1_recv/p1_error held 3 cycles; tgt_ack mirrors p1_ack; IDLE after the ack.
- Reset in BUSY: drop g_resetn one cycle while tgt_recv pending -> all outputs 0 next cycle; state IDLE. With IC_ARB_PERF_EN, counters read 0.
